// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port and a data port onto a single memory
//   request channel. Data requests normally win. A fetch that has waited
//   through STARVE_MAX consecutive data grants is granted next. A transfer
//   that gets no m_ack within TIMEOUT cycles is aborted. The abort returns
//   zero data and sets the sticky err flag.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_req/i_addr        fetch request (held until i_valid) and address
//   i_rdata/i_valid     fetch data and one-cycle completion pulse
//   d_rd/d_wr/d_addr    data read/write request (held until d_valid), address
//   d_wdata             write data
//   d_rdata/d_valid     read data and one-cycle completion pulse
//   m_req/m_wr          memory request and direction (1 = write)
//   m_addr/m_wdata      memory address and write data
//   m_rdata/m_ack       memory read data and completion
//   busy                high whenever the arbiter is not IDLE
//   err                 sticky: timeout or simultaneous read+write request
//
// Timing: a request seen in IDLE is granted at that edge, and m_req rises
// the next cycle. An m_ack sampled at the following edge moves the FSM to
// DONE, where the valid pulse is visible. That is three cycles from the
// cycle the request is raised to the valid cycle, inclusive.

module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        busy,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, IXFER, DXFER, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [7:0]    timeout_cnt;
  logic          data_req;
  logic          fetch_win;
  logic          tmo_hit;

  assign data_req  = d_rd | d_wr;
  assign fetch_win = i_req && (!data_req || (starve_cnt == SW'(STARVE_MAX)));
  // Fires on the cycle whose increment brings timeout_cnt to TIMEOUT, so
  // m_req stays high for exactly TIMEOUT cycles before the abort.
  assign tmo_hit   = !m_ack && (timeout_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (i_req || data_req) state_nxt = fetch_win ? IXFER : DXFER;
      IXFER, DXFER: if (m_ack || tmo_hit)  state_nxt = DONE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_req       <= 1'b0;
      m_wr        <= 1'b0;
      m_addr      <= 32'h0;
      m_wdata     <= 32'h0;
      i_rdata     <= 32'h0;
      d_rdata     <= 32'h0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      starve_cnt  <= '0;
      timeout_cnt <= 8'h0;
    end else begin
      busy    <= (state_nxt != IDLE);
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          timeout_cnt <= 8'h0;
          if (state_nxt == IXFER) begin
            m_req      <= 1'b1;
            m_wr       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= 32'h0;
            starve_cnt <= '0;
          end else if (state_nxt == DXFER) begin
            // A read+write collision is serviced as a write and flagged.
            m_req   <= 1'b1;
            m_wr    <= d_wr;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (d_rd && d_wr) err <= 1'b1;
            if (!i_req)                              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))  starve_cnt <= starve_cnt + 1'b1;
          end
        end
        IXFER, DXFER: begin
          if (m_ack) begin
            m_req <= 1'b0;
            if (state == IXFER) begin
              i_rdata <= m_rdata;
              i_valid <= 1'b1;
            end else begin
              if (!m_wr) d_rdata <= m_rdata;
              d_valid <= 1'b1;
            end
          end else begin
            timeout_cnt <= timeout_cnt + 8'h1;
            if (tmo_hit) begin
              m_req <= 1'b0;
              err   <= 1'b1;
              if (state == IXFER) begin
                i_rdata <= 32'h0;
                i_valid <= 1'b1;
              end else begin
                d_rdata <= 32'h0;
                d_valid <= 1'b1;
              end
            end
          end
        end
        default: ; // DONE: valid pulse is visible; no arbitration, m_ack ignored
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Expected grants are queued when requests
// are driven and then checked as the arbiter issues and completes them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_valid, d_valid, m_req, m_wr, busy, err;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
  );

  typedef struct {
    logic        fetch;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
  } txn_t;

  txn_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic fetch, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [31:0] mrdata);
    txn_t t;
    t.fetch = fetch; t.addr = addr; t.wr = wr; t.wdata = wdata; t.mrdata = mrdata;
    sb.push_back(t);
  endtask

  // Waits for the next grant, checks it against the queue head, acks after
  // lat cycles, checks the completion and then drops that requester.
  task automatic run_xfer(input int lat, input logic scramble);
    txn_t e;
    int   n;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!m_req && n < 20) begin tick; n++; end
    chk("grant_latency", 32'(n), 32'd1);
    chk("m_addr", m_addr, e.addr);
    chk("m_wr", 32'(m_wr), 32'(e.wr));
    if (e.wr) chk("m_wdata", m_wdata, e.wdata);
    for (int k = 0; k < lat; k++) begin
      if (scramble) begin i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; end
      tick;
      chk("m_req_hold", 32'(m_req), 32'd1);
      chk("m_addr_hold", m_addr, e.addr);
    end
    m_ack = 1'b1; m_rdata = e.mrdata;
    tick;
    m_ack = 1'b0; m_rdata = $urandom;
    if (e.fetch)      exp_i_rdata = e.mrdata;
    else if (!e.wr)   exp_d_rdata = e.mrdata;
    chk("m_req_drop", 32'(m_req), 32'd0);
    chk("i_valid", 32'(i_valid), 32'(e.fetch));
    chk("d_valid", 32'(d_valid), 32'(!e.fetch));
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("err", 32'(err), 32'(exp_err));
    if (e.fetch) i_req = 1'b0;
    else begin d_rd = 1'b0; d_wr = 1'b0; end
    tick;
    chk("valid_single", 32'({i_valid, d_valid}), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    // reset
    repeat (2) tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_valid", 32'({i_valid, d_valid}), 32'd0);
    rst_n = 1'b1;
    tick;

    // stray m_ack while idle is ignored
    m_ack = 1'b1; tick; m_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    tick;
    chk("idle_ack_valid", 32'({i_valid, d_valid}), 32'd0);

    // fetch only, ack one cycle after m_req, inputs wander during transfer
    i_req = 1'b1; i_addr = 32'h100;
    push(1'b1, 32'h100, 1'b0, 32'h0, 32'hA5A5A5A5);
    run_xfer(1, 1'b1);

    // simultaneous fetch and write: data first
    i_req = 1'b1; i_addr = 32'h300;
    d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234;
    push(1'b0, 32'h200, 1'b1, 32'h1234, 32'hDEAD0000);
    push(1'b1, 32'h300, 1'b0, 32'h0, 32'h0BADF00D);
    run_xfer(0, 1'b0);
    run_xfer(0, 1'b0);

    // starvation: 4 data grants then the fetch, twice (shows counter cleared)
    i_req = 1'b1; i_addr = 32'h500;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        d_rd = 1'b1; d_addr = 32'h400 + 32'(r * 16 + k * 4);
        push(1'b0, d_addr, 1'b0, 32'h0, 32'h1000 + 32'(r * 16 + k));
        run_xfer(0, 1'b0);
      end
      if (r == 0) begin d_rd = 1'b1; d_addr = 32'h410; end
      push(1'b1, 32'h500, 1'b0, 32'h0, 32'h5000 + 32'(r));
      run_xfer(0, 1'b0);
      if (r == 0) i_req = 1'b1;
    end

    // read+write collision: write issued, err set
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h900; d_wdata = 32'hCAFE;
    exp_err = 1'b1;
    push(1'b0, 32'h900, 1'b1, 32'hCAFE, 32'h77777777);
    run_xfer(0, 1'b0);

    // reset in the middle of a data transfer
    d_rd = 1'b1; d_addr = 32'h600;
    n = 0;
    while (!m_req && n < 20) begin tick; n++; end
    chk("rst_mid_granted", 32'(m_req), 32'd1);
    rst_n = 1'b0;
    tick;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_m_req", 32'(m_req), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    rst_n = 1'b1; d_rd = 1'b0;
    exp_err = 1'b0; exp_d_rdata = 32'h0; exp_i_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rst_mid_no_valid", 32'(d_valid), 32'd0);
    end

    // timeout: read with no m_ack
    d_rd = 1'b1; d_addr = 32'h700;
    n = 0;
    while (!m_req && n < 20) begin tick; n++; end
    n = 0;
    while (m_req && n < 300) begin tick; n++; end
    chk("timeout_cycles", 32'(n), 32'd255);
    chk("timeout_d_valid", 32'(d_valid), 32'd1);
    chk("timeout_d_rdata", d_rdata, 32'h0);
    chk("timeout_err", 32'(err), 32'd1);
    d_rd = 1'b0;
    tick;
    chk("timeout_pulse_end", 32'(d_valid), 32'd0);
    repeat (3) tick;
    chk("err_sticky", 32'(err), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction fetch waits.
REQ-002 Parameter TIMEOUT, default 255: cycles without m_ack before a transfer aborts; 8-bit counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  1  instruction fetch request; held high until i_valid.
REQ-006 i_addr  in  32  fetch address.
REQ-007 i_rdata  out  32  fetch data; registered.
REQ-008 i_valid  out  1  one-cycle fetch completion pulse.
REQ-009 d_rd  in  1  data read request; held until d_valid.
REQ-010 d_wr  in  1  data write request; held until d_valid.
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_rdata  out  32  read data; registered.
REQ-014 d_valid  out  1  one-cycle data completion pulse, for reads and writes.
REQ-015 m_req  out  1  memory request to the controller.
REQ-016 m_wr  out  1  1 = write, 0 = read; valid while m_req is high.
REQ-017 m_addr  out  32  memory address.
REQ-018 m_wdata  out  32  memory write data.
REQ-019 m_rdata  in  32  memory read data; valid with m_ack.
REQ-020 m_ack  in  1  memory completion; one cycle or longer.
REQ-021 busy  out  1  high whenever state is not IDLE.
REQ-022 err  out  1  sticky error flag.

Function
REQ-023 States: IDLE, IXFER, DXFER, DONE. All outputs come from registers.
REQ-024 IDLE, no request -> stay in IDLE.
REQ-025 IDLE, any request -> data wins, unless i_req=1 and starve_cnt==STARVE_MAX, in which case the fetch wins.
REQ-026 On grant, latch addr, wdata and wr into the m_* registers, go to IXFER/DXFER, and assert m_req from the next cycle.
REQ-027 starve_cnt: on a data grant with i_req=1, increment, saturating at STARVE_MAX; on a fetch grant, or a data grant with i_req=0, clear to 0.
REQ-028 In XFER, m_req and m_addr/m_wdata/m_wr are held stable until m_ack is sampled high.
REQ-029 XFER with m_ack=1:
  - drop m_req;
  - capture m_rdata into i_rdata (IXFER) or d_rdata (DXFER read); d_rdata is unchanged on a write;
  - go to DONE.
REQ-030 DONE: pulse the matching i_valid/d_valid for exactly one cycle, perform no arbitration, then go to IDLE.
REQ-031 Minimum latency, request to valid: 3 cycles when m_ack is returned in the first m_req cycle.
REQ-032 timeout_cnt clears on entry to XFER and increments each XFER cycle with m_ack=0.
REQ-033 When timeout_cnt reaches TIMEOUT:
  - drop m_req;
  - load the matching rdata with 32'h0;
  - set err;
  - go to DONE.
REQ-034 d_rd=1 and d_wr=1 together at grant: serviced as a write, and err is set.
REQ-035 m_ack while in IDLE or DONE is ignored.
REQ-036 err stays high until reset.
REQ-037 Request inputs are sampled only in IDLE; changes during XFER have no effect.

Reset
REQ-038 When rst_n is low at a rising edge:
  - state = IDLE;
  - m_req, m_wr, i_valid, d_valid, busy, err = 0;
  - m_addr, m_wdata, i_rdata, d_rdata = 32'h0;
  - starve_cnt = 0, timeout_cnt = 0.
REQ-039 Reset during XFER abandons the transfer: no valid pulse is produced, and m_req is low the first cycle after reset.

Verification
REQ-040 Fetch only: i_req=1, i_addr=0x100, m_ack 1 cycle after m_req with m_rdata=0xA5A5A5A5 -> m_addr=0x100, m_wr=0, i_valid one pulse, i_rdata=0xA5A5A5A5.
REQ-041 Simultaneous i_req and d_wr (d_addr=0x200, d_wdata=0x1234): data is granted first (m_wr=1, m_wdata=0x1234, d_valid pulse), then the fetch is granted.
REQ-042 Starvation: i_req held high while d_rd is re-asserted on every IDLE -> 4 data grants, then 1 fetch grant, then starve_cnt=0.
REQ-043 Timeout: d_rd with m_ack never asserted -> after 255 XFER cycles, m_req=0, d_valid pulse, d_rdata=0, err=1 stays high.
REQ-044 d_rd=d_wr=1 -> write issued and err=1.
REQ-045 Reset mid-transfer: rst_n low during DXFER -> next cycle busy=0, m_req=0, and no d_valid pulse.
